// File: rtl/fft_result_streamer_if.sv
// Result-buffer read port plus the outgoing AXI-style stream. The streamer side
// is the master: it drives the read strobe/address and the stream beats.
interface fft_result_streamer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [7:0]        m_tuser;

  modport master (
    output mem_rd_en, mem_addr, m_tdata, m_tvalid, m_tlast, m_tuser,
    input  mem_rdata, m_tready
  );

  modport slave (
    input  mem_rd_en, mem_addr, m_tdata, m_tvalid, m_tlast, m_tuser,
    output mem_rdata, m_tready
  );
endinterface

// File: rtl/fft_result_streamer.sv
// Reads N FFT results (optionally bit-reversed) from the result buffer and
// streams them out; a 2-entry FIFO hides the 1-cycle read latency.
module fft_result_streamer #(
  parameter int FFT_MAX_LENGTH_LOG2 = 12,
  parameter int FFT_MIN_LENGTH_LOG2 = 8,
  parameter int FFT_DATA_WIDTH      = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [3:0] length_log2_i,
  input  logic       bitrev_en_i,
  input  logic [7:0] scale_factor_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  fft_result_streamer_if.master bus
);
  localparam int AW = FFT_MAX_LENGTH_LOG2;
  localparam int DW = 2 * FFT_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  state_e state, state_nxt;

  logic [3:0]    len_q;
  logic          bitrev_q;
  logic [7:0]    scale_q;
  logic [AW:0]   rd_cnt;
  logic [AW:0]   n_val;
  logic          inflight;
  logic          inflight_last;

  entry_t [1:0]  fifo_mem;
  entry_t        head;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  logic          len_ok;
  logic          accept;
  logic          rd_en;
  logic          last_rd;
  logic          push;
  logic          pop;
  logic [2:0]    occ;

  logic [AW-1:0] cnt_lo;
  logic [AW-1:0] cnt_rev;
  logic [AW-1:0] addr_mask;
  logic [3:0]    rev_sh;

  assign len_ok = (length_log2_i >= 4'(FFT_MIN_LENGTH_LOG2)) &&
                  (length_log2_i <= 4'(FFT_MAX_LENGTH_LOG2));
  assign accept = (state == IDLE) && start_i && !abort_i && len_ok;

  assign n_val   = (AW+1)'(1) << len_q;
  assign last_rd = (rd_cnt == (n_val - (AW+1)'(1)));

  assign push = inflight;
  assign pop  = bus.m_tvalid & bus.m_tready;

  // Entries held plus the read already on its way must stay within 2
  // after this edge's pop, so the FIFO can never overflow.
  assign occ   = 3'(count) + 3'(inflight);
  assign rd_en = (state == STREAM) && (occ < (3'd2 + 3'(pop)));

  // Full-width reverse, then shift down so only the low L bits participate.
  assign cnt_lo = rd_cnt[AW-1:0];
  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < AW; i++) cnt_rev[i] = cnt_lo[AW-1-i];
  end
  assign rev_sh    = 4'(AW) - len_q;
  assign addr_mask = n_val[AW-1:0] - AW'(1);

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = (bitrev_q ? (cnt_rev >> rev_sh) : cnt_lo) & addr_mask;

  assign head         = fifo_mem[rd_ptr];
  assign bus.m_tvalid = (count != 2'd0);
  assign bus.m_tdata  = head.data;
  assign bus.m_tlast  = head.last;
  assign bus.m_tuser  = scale_q;

  always_comb begin
    state_nxt = state;
    busy_o    = (state == STREAM) || (state == DRAIN);
    done_o    = (state == DONE);
    case (state)
      IDLE:   if (accept) state_nxt = STREAM;
      STREAM: if (rd_en && last_rd) state_nxt = DRAIN;
      DRAIN:  if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop)))
                state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      error_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      error_o <= (state == IDLE) && start_i && !abort_i && !len_ok;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_q    <= '0;
      bitrev_q <= 1'b0;
      scale_q  <= '0;
      rd_cnt   <= '0;
    end else if (accept) begin
      len_q    <= length_log2_i;
      bitrev_q <= bitrev_en_i;
      scale_q  <= scale_factor_i;
      rd_cnt   <= '0;
    end else if (rd_en && !abort_i) begin
      rd_cnt   <= rd_cnt + (AW+1)'(1);
    end
  end

  // Abort drops both the buffered beats and the read still in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i || abort_i) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_mem      <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= '0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en & last_rd;
      if (push) fifo_mem[wr_ptr] <= '{last: inflight_last, data: bus.mem_rdata};
      wr_ptr        <= wr_ptr ^ push;
      rd_ptr        <= rd_ptr ^ pop;
      count         <= count + 2'(push) - 2'(pop);
    end
  end
endmodule
